// File: rtl/controlador_bcd_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// FSM encoding, operand width, range limit and shift-step count.
package pkg_bcd;

  localparam int LARGURA = 7;
  localparam int LIMITE  = 99;
  localparam int PASSOS  = 7;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

endpackage

// File: rtl/controlador_bcd_corretor.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module corretor4x4BCD (
  input  logic [3:0] digito,
  output logic [3:0] corrigido
);

  assign corrigido = (digito >= 4'd5) ? digito + 4'd3 : digito;

endmodule

// File: rtl/controlador_bcd.sv
// Two-requester, round-robin arbitrated binary-to-BCD converter. One operand
// is captured, converted by seven shift-and-correct steps, then published.
module controlador_bcd
  import pkg_bcd::*;
#(
  parameter int LARGURA = pkg_bcd::LARGURA,
  parameter int LIMITE  = pkg_bcd::LIMITE
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               ReqA,
  input  logic [LARGURA-1:0] BinA,
  input  logic               ReqB,
  input  logic [LARGURA-1:0] BinB,
  output logic               GntA,
  output logic               GntB,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [3:0]         Dezenas,
  output logic [3:0]         Unidades,
  output logic               Fonte,
  output logic               Erro
);

  estado_t            estado, estado_prox;
  logic [CNT_W-1:0]   contador;
  logic [LARGURA-1:0] operando;
  logic [3:0]         dez, uni;
  logic [3:0]         dez_cor, uni_cor;
  logic               fonte_int, erro_int;
  logic               prio_b;
  logic               captura, escolhe_b;
  logic [LARGURA-1:0] bin_sel;

  corretor4x4BCD u_cor_dez (.digito(dez), .corrigido(dez_cor));
  corretor4x4BCD u_cor_uni (.digito(uni), .corrigido(uni_cor));

  // Round-robin: B wins a tie only when A was the last one served.
  assign escolhe_b = ReqB & (~ReqA | prio_b);
  assign captura   = (estado == OCIOSO) & (ReqA | ReqB);
  assign bin_sel   = escolhe_b ? BinB : BinA;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) estado <= OCIOSO;
    else          estado <= estado_prox;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (captura) estado_prox = DESLOCA;
      DESLOCA: if (contador == '0) estado_prox = CONCLUI;
      CONCLUI: estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    Ocupado = 1'b0;
    Pronto  = 1'b0;
    case (estado)
      DESLOCA: Ocupado = 1'b1;
      CONCLUI: begin
        Ocupado = 1'b1;
        Pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      contador  <= '0;
      operando  <= '0;
      dez       <= '0;
      uni       <= '0;
      fonte_int <= 1'b0;
      erro_int  <= 1'b0;
      prio_b    <= 1'b0;
      GntA      <= 1'b0;
      GntB      <= 1'b0;
      Dezenas   <= '0;
      Unidades  <= '0;
      Fonte     <= 1'b0;
      Erro      <= 1'b0;
    end else begin
      GntA <= 1'b0;
      GntB <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (captura) begin
            operando  <= bin_sel;
            fonte_int <= escolhe_b;
            erro_int  <= (int'(bin_sel) > LIMITE);
            contador  <= CNT_W'(PASSOS);
            dez       <= '0;
            uni       <= '0;
            GntA      <= ~escolhe_b;
            GntB      <= escolhe_b;
            prio_b    <= ~escolhe_b;
          end
        end
        DESLOCA: begin
          if (contador != '0) begin
            // {tens, units, operand} <<= 1 after correcting both digits
            dez      <= {dez_cor[2:0], uni_cor[3]};
            uni      <= {uni_cor[2:0], operando[LARGURA-1]};
            operando <= {operando[LARGURA-2:0], 1'b0};
            contador <= contador - 1'b1;
          end else begin
            Dezenas  <= erro_int ? 4'd9 : dez;
            Unidades <= erro_int ? 4'd9 : uni;
            Fonte    <= fonte_int;
            Erro     <= erro_int;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_bcd.sv
// Scoreboard bench for controlador_bcd: drivers queue expected results,
// a negedge monitor checks every Pronto pulse, grant overlap and latency.
module tb_controlador_bcd;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ReqA = 1'b0, ReqB = 1'b0;
  logic [6:0] BinA = '0, BinB = '0;
  logic       GntA, GntB, Ocupado, Pronto, Fonte, Erro;
  logic [3:0] Dezenas, Unidades;

  typedef struct {
    int dez;
    int uni;
    int fonte;
    int erro;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, gnt_cyc = -100;

  controlador_bcd dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ReqA(ReqA), .BinA(BinA), .ReqB(ReqB), .BinB(BinB),
    .GntA(GntA), .GntB(GntB), .Ocupado(Ocupado), .Pronto(Pronto),
    .Dezenas(Dezenas), .Unidades(Unidades), .Fonte(Fonte), .Erro(Erro)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int all_outs();
    return int'({GntA, GntB, Ocupado, Pronto, Dezenas, Unidades, Fonte, Erro});
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge Clock);
    cyc++;
    if (GntA || GntB) begin
      check("gnt_overlap", int'(GntA && GntB), 0);
      gnt_cyc = cyc;
    end
    if (Pronto) begin
      if (sb.size() == 0) begin
        check("pronto_unexpected", int'(Pronto), 0);
      end else begin
        e = sb.pop_front();
        check("dezenas", int'(Dezenas), e.dez);
        check("unidades", int'(Unidades), e.uni);
        check("fonte", int'(Fonte), e.fonte);
        check("erro", int'(Erro), e.erro);
        check("latency", cyc - gnt_cyc, 8);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && Ocupado; i++) begin
      @(posedge Clock); #1;
    end
    check("idle_timeout", int'(Ocupado), 0);
  endtask

  // Caller is at a falling edge; request is held for exactly one capture edge.
  task automatic issue(input bit b, input logic [6:0] v, input logic [6:0] later,
                       input int d, input int u, input int er);
    if (b) begin ReqB = 1'b1; BinB = v; end
    else   begin ReqA = 1'b1; BinA = v; end
    sb.push_back(exp_t'{d, u, int'(b), er});
    @(posedge Clock); #1;
    check(b ? "gnt_b" : "gnt_a", int'(b ? GntB : GntA), 1);
    check("ocupado_busy", int'(Ocupado), 1);
    ReqA = 1'b0;
    ReqB = 1'b0;
    if (b) BinB = later;
    else   BinA = later;
    wait_idle();
  endtask

  task automatic wait_prontos(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(posedge Clock); #1;
      if (Pronto) seen++;
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
    check("held_timeout", seen, n);
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(negedge Clock); Reset_n = 1'b0;
    @(negedge Clock); Reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("reset_outputs", all_outs(), 0);

    // First request together with reset release: granted on the first edge.
    Reset_n = 1'b1;
    issue(1'b0, 7'd45, 7'd45, 4, 5, 0);

    // Simultaneous after reset: A first, then B.
    pulse_reset();
    @(negedge Clock);
    ReqA = 1'b1; ReqB = 1'b1; BinA = 7'd12; BinB = 7'd99;
    sb.push_back(exp_t'{1, 2, 0, 0});
    sb.push_back(exp_t'{9, 9, 1, 0});
    wait_prontos(2);

    // Held continuously: B was served last, so A, B, A, B.
    @(negedge Clock);
    ReqA = 1'b1; ReqB = 1'b1; BinA = 7'd21; BinB = 7'd84;
    sb.push_back(exp_t'{2, 1, 0, 0});
    sb.push_back(exp_t'{8, 4, 1, 0});
    sb.push_back(exp_t'{2, 1, 0, 0});
    sb.push_back(exp_t'{8, 4, 1, 0});
    wait_prontos(4);

    // Range boundaries.
    @(negedge Clock); issue(1'b1, 7'd127, 7'd127, 9, 9, 1);
    @(negedge Clock); issue(1'b0, 7'd0, 7'd0, 0, 0, 0);
    @(negedge Clock); issue(1'b1, 7'd100, 7'd100, 9, 9, 1);

    // Operand changes after capture are ignored.
    @(negedge Clock); issue(1'b0, 7'd58, 7'd3, 5, 8, 0);

    // Reset mid-conversion: outputs clear at once, no Pronto follows.
    @(negedge Clock);
    ReqA = 1'b1; BinA = 7'd33;
    @(posedge Clock); #1;
    ReqA = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1 check("reset_mid", all_outs(), 0);
    @(negedge Clock); Reset_n = 1'b1;
    repeat (15) @(posedge Clock);
    @(negedge Clock); issue(1'b0, 7'd70, 7'd70, 7, 0, 0);

    repeat (3) @(negedge Clock);
    check("pending", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_bcd.md
CONTROLADOR_BCD -- requirements
Module: controlador_bcd

Interface
REQ-001 Parameter: LARGURA, 7, operand width in bits; fixed at 7 for this block.
REQ-002 Parameter: LIMITE, 99, largest operand representable in two BCD digits.
REQ-003 Port: Clock  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: ReqA  in  1  requester A conversion request, level.
REQ-006 Port: BinA  in  7  requester A binary operand, valid while ReqA=1.
REQ-007 Port: ReqB  in  1  requester B conversion request, level.
REQ-008 Port: BinB  in  7  requester B binary operand, valid while ReqB=1.
REQ-009 Port: GntA  out  1  one-cycle pulse: the A operand was captured.
REQ-010 Port: GntB  out  1  one-cycle pulse: the B operand was captured.
REQ-011 Port: Ocupado  out  1  high while a conversion is in progress.
REQ-012 Port: Pronto  out  1  one-cycle pulse: the result is valid.
REQ-013 Port: Dezenas  out  4  BCD tens digit of the last result.
REQ-014 Port: Unidades  out  4  BCD units digit of the last result.
REQ-015 Port: Fonte  out  1  source of the last result: 0=A, 1=B.
REQ-016 Port: Erro  out  1  last operand exceeded LIMITE.

Function
REQ-017 The FSM SHALL have exactly three states: OCIOSO, DESLOCA and CONCLUI.
REQ-018 In OCIOSO with any request pending, the controller SHALL, on one edge, capture the granted operand, pulse the matching Gnt for the following cycle, load the step counter with 7, clear the internal digits, and enter DESLOCA.
REQ-019 Arbitration SHALL be round-robin: a single request is granted directly; on simultaneous requests, the requester not served last is granted; after reset, A has priority.
REQ-020 Each DESLOCA cycle SHALL apply the per-digit correction to both internal digits (+3 when the digit is 5 or greater), then shift {tens, units, operand} left by one bit, inserting the operand MSB into units bit 0, and decrement the counter.
REQ-021 When the counter reaches 0, the FSM SHALL enter CONCLUI and register Dezenas, Unidades, Fonte and Erro.
REQ-022 Pronto SHALL be high for exactly the one cycle spent in CONCLUI.
REQ-023 Timing: with the capture edge as edge 0, Pronto SHALL be high in the cycle after edge 8.
REQ-024 The FSM SHALL return to OCIOSO on the next edge.
REQ-025 Ocupado SHALL be 1 in DESLOCA and CONCLUI and 0 in OCIOSO.
REQ-026 Operands greater than LIMITE (100..127) SHALL produce Dezenas=9, Unidades=9 and Erro=1; otherwise Erro SHALL be 0.
REQ-027 Requests are sampled only in OCIOSO.
REQ-028 Operand changes after capture SHALL be ignored.
REQ-029 A Req still high after its Gnt SHALL be treated as a new request.
REQ-030 Dezenas, Unidades, Fonte and Erro SHALL hold their values until the next CONCLUI.
REQ-031 At most one Gnt SHALL be high in any cycle, and none outside the cycle following a capture edge.

Reset
REQ-032 Reset_n=0 SHALL asynchronously force state OCIOSO, counter 0, internal digits 0, and priority to A.
REQ-033 Reset_n=0 SHALL asynchronously force all outputs to 0: GntA, GntB, Ocupado, Pronto, Dezenas, Unidades, Fonte and Erro.
REQ-034 Reset asserted mid-conversion SHALL discard that conversion, with no Pronto pulse afterwards.
REQ-035 After Reset_n rises, the first request SHALL be accepted on the first rising edge.

Structure
REQ-036 Shared package pkg_bcd SHALL hold the state encoding, LARGURA, LIMITE and the step count 7.
REQ-037 The per-digit +3 correction SHALL reuse the existing corretor4x4BCD sub-module, instantiated twice (tens and units).
REQ-038 Iterative conversion SHALL replace the seven unrolled correction stages.

Verification
REQ-039 Reset, then ReqA=1, BinA=45 for one cycle -> GntA pulse; Pronto 8 cycles after the capture edge with Dezenas=4, Unidades=5, Fonte=0, Erro=0.
REQ-040 After reset, ReqA=ReqB=1 held with BinA=12 and BinB=99 -> A served first (1,2; Fonte=0), then B (9,9; Fonte=1).
REQ-041 Both requests held continuously -> grants alternate A,B,A,B and never overlap.
REQ-042 BinB=127 -> Dezenas=9, Unidades=9, Erro=1; BinA=0 -> 0,0, Erro=0.
REQ-043 Reset_n pulsed low during DESLOCA -> outputs immediately 0, no Pronto; a new ReqA=1 with BinA=70 -> 7,0.
REQ-044 BinA changed during DESLOCA -> result reflects the captured value.
